// File: rtl/pipelined_addsub_unit_pkg.sv
// Shared ALU definitions: operation encodings and default datapath geometry.
package alu_pkg;

   localparam int ALU_WIDTH     = 32;
   localparam int ALU_SEG_WIDTH = 8;

   typedef enum logic [1:0] {
      OP_ADD  = 2'b00,
      OP_SUB  = 2'b01,
      OP_SLT  = 2'b10,
      OP_SLTU = 2'b11
   } alu_op_t;

endpackage

// File: rtl/pipelined_addsub_unit_if.sv
// Operand/result stream bundle for the pipelined add/sub unit.
interface pipelined_addsub_unit_if
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
);

   logic             in_valid;
   logic             in_ready;
   alu_op_t          op;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             carry;
   logic             overflow;
   logic             zero;

   // master: the client issuing operands and consuming results
   modport master (
      output in_valid, op, x, y, out_ready,
      input  in_ready, out_valid, result, carry, overflow, zero
   );

   modport slave (
      input  in_valid, op, x, y, out_ready,
      output in_ready, out_valid, result, carry, overflow, zero
   );

endinterface

// File: rtl/pipelined_addsub_unit_slice.sv
// One carry-chain slice: SEG_WIDTH-bit adder plus the stage register that
// follows it. The register payload is assembled by the parent stage.
module addsub_slice
   import alu_pkg::*;
#(
   parameter int SEG_WIDTH = ALU_SEG_WIDTH,
   parameter int DW        = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_en,
   input  logic [SEG_WIDTH-1:0] i_a,
   input  logic [SEG_WIDTH-1:0] i_b,
   input  logic                 i_cin,
   output logic [SEG_WIDTH-1:0] o_sum,
   output logic                 o_cout,
   input  logic [DW-1:0]        i_d,
   output logic [DW-1:0]        o_q
);

   logic [DW-1:0] r_q;

   assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{SEG_WIDTH{1'b0}}, i_cin};

   always_ff @(posedge clk) begin
      if (rst)
         r_q <= '0;
      else if (i_en)
         r_q <= i_d;
   end

   assign o_q = r_q;

endmodule

// File: rtl/pipelined_addsub_unit.sv
// Pipelined ADD/SUB/SLT/SLTU unit: one carry-chain slice per stage, global
// stall on back-pressure, flags resolved in the last stage. Needs NSTAGE >= 2.
module pipelined_addsub_unit
   import alu_pkg::*;
#(
   parameter int WIDTH     = ALU_WIDTH,
   parameter int SEG_WIDTH = ALU_SEG_WIDTH
) (
   input logic                     clk,
   input logic                     rst,
   pipelined_addsub_unit_if.slave  bus
);

   localparam int NSTAGE = WIDTH / SEG_WIDTH;

   logic             w_adv;
   logic             w_cin;
   logic [WIDTH-1:0] w_b;

   assign w_adv       = !bus.out_valid || bus.out_ready;
   assign bus.in_ready = w_adv;

   // Subtract-type ops fold the +1 into the slice-0 carry-in.
   assign w_cin = (bus.op != OP_ADD);
   assign w_b   = w_cin ? ~bus.y : bus.y;

   for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
      // sx: resolved sum in the low k slices, untouched x above them.
      // bu: b bits from slice k upward, right-aligned.
      localparam int LO   = k * SEG_WIDTH;
      localparam int BI_W = WIDTH - LO;
      localparam int DW   = (k < NSTAGE-1) ? (4 + WIDTH + BI_W - SEG_WIDTH) : (WIDTH + 4);

      logic [WIDTH-1:0]     w_sx_in;
      logic [BI_W-1:0]      w_bu_in;
      logic                 w_ci;
      logic                 w_vi;
      alu_op_t              w_op_in;
      logic [SEG_WIDTH-1:0] w_sum;
      logic                 w_co;
      logic [DW-1:0]        w_d;
      logic [DW-1:0]        w_q;

      if (k == 0) begin : g_first
         assign w_sx_in = bus.x;
         assign w_bu_in = w_b;
         assign w_ci    = w_cin;
         assign w_vi    = bus.in_valid;
         assign w_op_in = bus.op;
      end else begin : g_next
         assign w_sx_in = g_stage[k-1].g_mid.w_sx_q;
         assign w_bu_in = g_stage[k-1].g_mid.w_bu_q;
         assign w_ci    = g_stage[k-1].g_mid.w_co_q;
         assign w_vi    = g_stage[k-1].g_mid.w_vld_q;
         assign w_op_in = g_stage[k-1].g_mid.w_op_q;
      end

      addsub_slice #(
         .SEG_WIDTH (SEG_WIDTH),
         .DW        (DW)
      ) u_slice (
         .clk    (clk),
         .rst    (rst),
         .i_en   (w_adv),
         .i_a    (w_sx_in[LO +: SEG_WIDTH]),
         .i_b    (w_bu_in[SEG_WIDTH-1:0]),
         .i_cin  (w_ci),
         .o_sum  (w_sum),
         .o_cout (w_co),
         .i_d    (w_d),
         .o_q    (w_q)
      );

      if (k < NSTAGE-1) begin : g_mid
         localparam int UP_W = BI_W - SEG_WIDTH;

         logic [WIDTH-1:0] w_sx_nx;
         logic [WIDTH-1:0] w_sx_q;
         logic [UP_W-1:0]  w_bu_q;
         logic             w_co_q;
         logic             w_vld_q;
         alu_op_t          w_op_q;

         always_comb begin
            w_sx_nx                     = w_sx_in;
            w_sx_nx[LO +: SEG_WIDTH]    = w_sum;
         end

         assign w_d = {w_vi, w_op_in, w_co, w_sx_nx, w_bu_in[BI_W-1:SEG_WIDTH]};

         assign w_bu_q  = w_q[UP_W-1:0];
         assign w_sx_q  = w_q[UP_W +: WIDTH];
         assign w_co_q  = w_q[UP_W+WIDTH];
         assign w_op_q  = alu_op_t'(w_q[UP_W+WIDTH+1 +: 2]);
         assign w_vld_q = w_q[DW-1];
      end else begin : g_last
         logic [WIDTH-1:0] w_s;
         logic [WIDTH-1:0] w_res;
         logic             w_xm;
         logic             w_bm;
         logic             w_v;
         logic             w_zero;

         always_comb begin
            w_s                  = w_sx_in;
            w_s[LO +: SEG_WIDTH] = w_sum;
            w_xm                 = w_sx_in[WIDTH-1];
            w_bm                 = w_bu_in[SEG_WIDTH-1];
            w_v                  = (w_xm == w_bm) && (w_s[WIDTH-1] != w_xm);
            w_res                = w_s;
            if (w_op_in == OP_SLT)
               w_res = {{(WIDTH-1){1'b0}}, w_s[WIDTH-1] ^ w_v};
            else if (w_op_in == OP_SLTU)
               w_res = {{(WIDTH-1){1'b0}}, ~w_co};
            w_zero               = (w_res == '0);
         end

         // The final stage register doubles as the output register.
         assign w_d = {w_vi, w_res, w_co, w_v, w_zero};

         assign bus.out_valid = w_q[WIDTH+3];
         assign bus.result    = w_q[WIDTH+2:3];
         assign bus.carry     = w_q[2];
         assign bus.overflow  = w_q[1];
         assign bus.zero      = w_q[0];
      end
   end

endmodule

// File: tb/tb_pipelined_addsub_unit.sv
// Directed bench for pipelined_addsub_unit: reset, latency, streaming,
// back-pressure hold, carry ripple and mid-stream reset.
module tb_pipelined_addsub_unit;
   import alu_pkg::*;

   localparam int W  = ALU_WIDTH;
   localparam int NS = ALU_WIDTH / ALU_SEG_WIDTH;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   pipelined_addsub_unit_if #(.WIDTH(W)) bus ();

   pipelined_addsub_unit #(
      .WIDTH     (W),
      .SEG_WIDTH (ALU_SEG_WIDTH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      alu_op_t     op;
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] res;
      logic        c;
      logic        v;
      logic        z;
   } vec_t;

   vec_t vt[$];
   int   n_chk = 0;
   int   n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic add(input alu_op_t op, input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] res, input logic c, input logic v, input logic z);
      vec_t e;
      e.op = op; e.x = x; e.y = y; e.res = res; e.c = c; e.v = v; e.z = z;
      vt.push_back(e);
   endtask

   task automatic idle();
      bus.in_valid = 1'b0;
      bus.op       = OP_ADD;
      bus.x        = '0;
      bus.y        = '0;
   endtask

   task automatic drive(input int i);
      bus.in_valid = 1'b1;
      bus.op       = vt[i].op;
      bus.x        = vt[i].x;
      bus.y        = vt[i].y;
   endtask

   task automatic check_out(input int i);
      chk($sformatf("v%0d.result", i),   bus.result,   vt[i].res);
      chk($sformatf("v%0d.carry", i),    bus.carry,    vt[i].c);
      chk($sformatf("v%0d.overflow", i), bus.overflow, vt[i].v);
      chk($sformatf("v%0d.zero", i),     bus.zero,     vt[i].z);
   endtask

   // One isolated beat; measures cycles from presentation to out_valid.
   task automatic single(input int i);
      int lat = -1;
      @(posedge clk); #1;
      drive(i);
      bus.out_ready = 1'b1;
      for (int c = 1; c <= 12 && lat < 0; c++) begin
         @(posedge clk); #1;
         idle();
         #1;
         if (bus.out_valid) begin
            lat = c;
            check_out(i);
         end
      end
      chk($sformatf("v%0d.latency", i), lat, NS);
   endtask

   task automatic run_stream(input int first, input int n, input int stall_from,
                             input int stall_len, input int budget);
      int               wr = 0;
      int               rd = 0;
      int               cyc = 0;
      logic             held_v = 1'b0;
      logic [W-1:0]     held_r = '0;
      while (rd < n && cyc < budget) begin
         @(posedge clk); #1;
         if (wr < n) drive(first + wr);
         else        idle();
         bus.out_ready = !(cyc >= stall_from && cyc < stall_from + stall_len);
         #1;
         if (held_v) begin
            chk("hold.valid",  bus.out_valid, 1'b1);
            chk("hold.result", bus.result,    held_r);
         end
         if (bus.out_valid && !bus.out_ready)
            chk("stall.in_ready", bus.in_ready, 1'b0);
         if (rd > 0 && bus.out_ready)
            chk($sformatf("rate.beat%0d", rd), bus.out_valid, 1'b1);
         held_v = bus.out_valid && !bus.out_ready;
         held_r = bus.result;
         if (bus.out_valid && bus.out_ready) begin
            check_out(first + rd);
            rd++;
         end
         if (bus.in_valid && bus.in_ready) wr++;
         cyc++;
      end
      chk("stream.count", rd, n);
      @(posedge clk); #1;
      idle();
      bus.out_ready = 1'b1;
      repeat (NS + 1) @(posedge clk);
      #1 chk("stream.drained", bus.out_valid, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //   op       x             y             result        c     v     z
      add(OP_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0);
      add(OP_SUB,  32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
      add(OP_SUB,  32'h00000007, 32'h00000007, 32'h00000000, 1'b1, 1'b0, 1'b1);
      add(OP_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b1, 1'b0, 1'b0);
      add(OP_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1);
      add(OP_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1);
      add(OP_ADD,  32'h000000FF, 32'h00000001, 32'h00000100, 1'b0, 1'b0, 1'b0);
      add(OP_SLT,  32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 1'b1);
      add(OP_SLTU, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0);
      add(OP_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
      add(OP_SLT,  32'h80000000, 32'h00000001, 32'h00000001, 1'b1, 1'b1, 1'b0);
      add(OP_ADD,  32'h0000FFFF, 32'h00010001, 32'h00020000, 1'b0, 1'b0, 1'b0);

      rst           = 1'b1;
      bus.out_ready = 1'b0;
      idle();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      chk("rst.out_valid", bus.out_valid, 1'b0);
      chk("rst.result",    bus.result,    '0);
      chk("rst.carry",     bus.carry,     1'b0);
      chk("rst.overflow",  bus.overflow,  1'b0);
      chk("rst.zero",      bus.zero,      1'b0);
      chk("rst.in_ready",  bus.in_ready,  1'b1);

      for (int i = 0; i < 7; i++) single(i);

      run_stream(0, vt.size(), 1000, 0, 80);
      run_stream(0, 6, 5, 8, 80);

      // Three beats in flight, then a one-cycle reset before any emerges.
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      drive(9);
      @(posedge clk); #1 drive(10);
      @(posedge clk); #1 drive(11);
      @(posedge clk); #1;
      idle();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("midrst.out_valid", bus.out_valid, 1'b0);
      chk("midrst.in_ready",  bus.in_ready,  1'b1);
      for (int c = 0; c < NS + 2; c++) begin
         @(posedge clk); #2;
         chk($sformatf("midrst.flush%0d", c), bus.out_valid, 1'b0);
      end
      single(1);
      for (int c = 0; c < NS; c++) begin
         @(posedge clk); #2;
         chk($sformatf("midrst.tail%0d", c), bus.out_valid, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
